countdown_timer_module: RTL and testbench

COUNTDOWN_TIMER_MODULE -- requirements
Module: countdown_timer_module

---
 rtl/countdown_timer_module.sv | 107 ++++++++++
 tb/tb_countdown_timer_module.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_module.sv
// mm:ss BCD countdown timer with keypad shift-in entry and 1 Hz tick.
// Define TIMER_DONE_PULSE_EN to build the registered end-of-count done pulse.
module countdown_timer_module (
    input  logic       clock_100Hz,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       count_enablen,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       done
);

    logic       loadn_q;
    logic       pgt_q;
    logic       load_ev;
    logic       tick_ev;
    logic       do_load;
    logic       do_dec;
    logic [3:0] n_so;
    logic [3:0] n_st;
    logic [3:0] n_mo;
    logic [3:0] n_mt;

    assign load_ev = loadn_q & ~loadn;
    assign tick_ev = ~pgt_q & pgt_1Hz;
    assign zero    = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                     (min_ones == 4'd0) && (min_tens == 4'd0);
    assign do_load = load_ev & count_enablen & (D <= 4'd9);
    assign do_dec  = tick_ev & ~count_enablen & ~zero;

    always_comb begin
        n_so = sec_ones;
        n_st = sec_tens;
        n_mo = min_ones;
        n_mt = min_tens;
        if (do_load) begin
            n_mt = min_ones;
            n_mo = sec_tens;
            n_st = sec_ones;
            n_so = D;
        end else if (do_dec) begin
            // Borrow ripples left only through zero digits.
            if (sec_ones != 4'd0) begin
                n_so = sec_ones - 4'd1;
            end else begin
                n_so = 4'd9;
                if (sec_tens != 4'd0) begin
                    n_st = sec_tens - 4'd1;
                end else begin
                    n_st = 4'd5;
                    if (min_ones != 4'd0) begin
                        n_mo = min_ones - 4'd1;
                    end else begin
                        n_mo = 4'd9;
                        n_mt = min_tens - 4'd1;
                    end
                end
            end
        end
    end

    // Edge detectors reset to the "already asserted" level so held inputs
    // across reset release do not fire.
    always_ff @(posedge clock_100Hz or posedge clear) begin
        if (clear) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            loadn_q  <= 1'b0;
            pgt_q    <= 1'b1;
        end else begin
            sec_ones <= n_so;
            sec_tens <= n_st;
            min_ones <= n_mo;
            min_tens <= n_mt;
            loadn_q  <= loadn;
            pgt_q    <= pgt_1Hz;
        end
    end

`ifdef TIMER_DONE_PULSE_EN
    logic dec_zero;
    logic done_q;

    assign dec_zero = do_dec && (n_so == 4'd0) && (n_st == 4'd0) &&
                      (n_mo == 4'd0) && (n_mt == 4'd0);

    always_ff @(posedge clock_100Hz or posedge clear) begin
        if (clear) begin
            done_q <= 1'b0;
        end else begin
            done_q <= dec_zero;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_module.sv
// Bench for countdown_timer_module: vector table, directed corner cases
// and randomized traffic against an arithmetic mm:ss reference model.
module tb_countdown_timer_module;

`ifdef TIMER_DONE_PULSE_EN
    localparam bit DP = 1'b1;
`else
    localparam bit DP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b0;
    logic       pgt = 1'b1;
    logic       cen = 1'b1;
    logic [3:0] so, st, mo, mt;
    logic       zero, done;

    int total = 0;
    int passed = 0;

    int m_d[4];
    bit m_lq, m_pq, m_done;

    always #5 clk = ~clk;

    countdown_timer_module dut (
        .clock_100Hz  (clk),
        .clear        (clear),
        .D            (D),
        .loadn        (loadn),
        .pgt_1Hz      (pgt),
        .count_enablen(cen),
        .sec_ones     (so),
        .sec_tens     (st),
        .min_ones     (mo),
        .min_tens     (mt),
        .zero         (zero),
        .done         (done)
    );

    typedef struct {
        bit       clr;
        bit       ce;
        bit [3:0] d;
        bit       ln;
        bit       pg;
        bit [15:0] disp;
        bit       z;
    } vec_t;

    function automatic bit m_zero();
        return (m_d[0] == 0) && (m_d[1] == 0) && (m_d[2] == 0) && (m_d[3] == 0);
    endfunction

    task automatic model_clock();
        bit ld, tk;
        int s, m;
        if (clear) begin
            m_d = '{0, 0, 0, 0};
            m_lq = 1'b0;
            m_pq = 1'b1;
            m_done = 1'b0;
            return;
        end
        ld = m_lq && !loadn;
        tk = !m_pq && pgt;
        m_done = 1'b0;
        if (ld && cen && D <= 9) begin
            m_d[3] = m_d[2];
            m_d[2] = m_d[1];
            m_d[1] = m_d[0];
            m_d[0] = int'(D);
        end else if (tk && !cen && !m_zero()) begin
            s = m_d[1] * 10 + m_d[0];
            m = m_d[3] * 10 + m_d[2];
            if (s > 0) s = s - 1;
            else begin
                s = 59;
                m = m - 1;
            end
            m_d[0] = s % 10;
            m_d[1] = s / 10;
            m_d[2] = m % 10;
            m_d[3] = m / 10;
            m_done = DP && m_zero();
        end
        m_lq = loadn;
        m_pq = pgt;
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic int disp();
        return int'({mt, mo, st, so});
    endfunction

    function automatic int m_disp();
        return (m_d[3] << 12) | (m_d[2] << 8) | (m_d[1] << 4) | m_d[0];
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check("model_disp", disp(), m_disp());
        check("model_zero", int'(zero), int'(m_zero()));
        check("model_done", int'(done), int'(m_done));
    endtask

    task automatic load_digit(input int d);
        D = 4'(d);
        loadn = 1'b0;
        step();
        loadn = 1'b1;
        step();
    endtask

    task automatic tick();
        pgt = 1'b1;
        step();
        pgt = 1'b0;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        loadn = 1'b1;
        pgt = 1'b0;
        step();
    endtask

    vec_t vt[15];

    initial begin
        vt[0]  = '{1, 1, 0, 0, 1, 16'h0000, 1};
        vt[1]  = '{0, 1, 0, 0, 1, 16'h0000, 1};
        vt[2]  = '{0, 1, 0, 1, 1, 16'h0000, 1};
        vt[3]  = '{0, 1, 1, 0, 1, 16'h0001, 0};
        vt[4]  = '{0, 1, 1, 1, 1, 16'h0001, 0};
        vt[5]  = '{0, 1, 2, 0, 1, 16'h0012, 0};
        vt[6]  = '{0, 1, 2, 1, 1, 16'h0012, 0};
        vt[7]  = '{0, 1, 3, 0, 1, 16'h0123, 0};
        vt[8]  = '{0, 1, 3, 1, 1, 16'h0123, 0};
        vt[9]  = '{0, 1, 0, 0, 1, 16'h1230, 0};
        vt[10] = '{0, 1, 0, 1, 1, 16'h1230, 0};
        vt[11] = '{0, 1, 11, 0, 1, 16'h1230, 0};
        vt[12] = '{0, 1, 11, 1, 1, 16'h1230, 0};
        vt[13] = '{0, 1, 0, 1, 0, 16'h1230, 0};
        vt[14] = '{0, 1, 0, 1, 1, 16'h1230, 0};

        m_d = '{0, 0, 0, 0};
        m_lq = 1'b0;
        m_pq = 1'b1;
        m_done = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            clear = vt[i].clr;
            cen   = vt[i].ce;
            D     = vt[i].d;
            loadn = vt[i].ln;
            pgt   = vt[i].pg;
            step();
            check($sformatf("vec%0d_disp", i), disp(), int'(vt[i].disp));
            check($sformatf("vec%0d_zero", i), int'(zero), int'(vt[i].z));
            check($sformatf("vec%0d_done", i), int'(done), 0);
        end

        // loadn held low: single shift
        pgt = 1'b0;
        D = 4'd4;
        loadn = 1'b0;
        for (int i = 0; i < 30; i++) step();
        loadn = 1'b1;
        step();
        check("held_loadn", disp(), 16'h2304);

        // borrow chain
        do_clear();
        load_digit(1); load_digit(0); load_digit(0); load_digit(0);
        check("load_1000", disp(), 16'h1000);
        cen = 1'b0;
        tick();
        check("borrow_0959", disp(), 16'h0959);
        tick();
        check("tick_0958", disp(), 16'h0958);
        load_digit(5);
        check("load_ignored", disp(), 16'h0958);

        // end of count
        cen = 1'b1;
        do_clear();
        load_digit(0); load_digit(0);
        check("load_zero_done", int'(done), 0);
        load_digit(0); load_digit(2);
        cen = 1'b0;
        pgt = 1'b1; step();
        check("eoc_0001", disp(), 16'h0001);
        check("eoc_zero0", int'(zero), 0);
        pgt = 1'b0; step();
        pgt = 1'b1; step();
        check("eoc_0000", disp(), 16'h0000);
        check("eoc_zero1", int'(zero), 1);
        check("eoc_done", int'(done), int'(DP));
        pgt = 1'b0; step();
        check("eoc_done_fall", int'(done), 0);
        tick();
        check("eoc_nowrap", disp(), 16'h0000);
        check("eoc_no_redone", int'(done), 0);

        // pause / resume / abort
        cen = 1'b1;
        do_clear();
        load_digit(0); load_digit(1); load_digit(0); load_digit(0);
        cen = 1'b0;
        tick();
        check("pause_0059", disp(), 16'h0059);
        cen = 1'b1;
        repeat (3) tick();
        check("pause_frozen", disp(), 16'h0059);
        cen = 1'b0;
        tick();
        check("resume_0058", disp(), 16'h0058);
        clear = 1'b1;
        #1;
        check("abort_disp", disp(), 16'h0000);
        check("abort_done", int'(done), 0);
        step();
        clear = 1'b0;
        step();
        tick();
        check("after_abort", disp(), 16'h0000);

        // maximum entry
        cen = 1'b1;
        repeat (4) load_digit(9);
        check("load_9999", disp(), 16'h9999);
        cen = 1'b0;
        repeat (10) tick();
        check("count_9989", disp(), 16'h9989);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) cen = ~cen;
            loadn = ($urandom_range(0, 3) != 0);
            pgt = ($urandom_range(0, 2) != 0) ? pgt : ~pgt;
            D = 4'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
